// File: rtl/bclk_train_pkg.sv
// Shared types and defaults for the BCLK delay-line training controller.
// Optional eye-monitor gating is selected with BCLK_TRAIN_EYE_MON_EN.
package bclk_train_pkg;

  localparam int unsigned DEF_TAP_W         = 8;
  localparam int unsigned DEF_MAX_TAPS      = 128;
  localparam int unsigned DEF_SETTLE_CYCLES = 8;
  localparam int unsigned DEF_SAMPLE_CYCLES = 16;

  localparam logic [7:0] PASS_REJECT_LO = 8'h00;
  localparam logic [7:0] PASS_REJECT_HI = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_STEP,
    S_CALC,
    S_RELOAD,
    S_SEEK,
    S_DONE,
    S_FAIL
  } train_state_t;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_SETTLE,
    CHK_SAMPLE
  } chk_phase_t;

  // A stuck-low or stuck-high lane carries no clock edge, so it never counts as a pass.
  function automatic logic word_rejected(input logic [7:0] w);
    return (w == PASS_REJECT_LO) || (w == PASS_REJECT_HI);
  endfunction

endpackage

// File: rtl/bclk_sample_chk.sv
// Per-tap settle/sample sequencer: waits out the settle time, then checks the
// sampled words for stability. Eye flags gate the result under BCLK_TRAIN_EYE_MON_EN.
module bclk_sample_chk
  import bclk_train_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  input  logic       i_eye_early,
  input  logic       i_eye_late,
  output logic       o_settle_done,
  output logic       o_done,
  output logic       o_pass
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);

  chk_phase_t    r_phase;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_ref;
  logic          r_ok;
  logic          r_pass;

  logic       w_first;
  logic [7:0] w_ref;
  logic       w_eye_ok;
  logic       w_word_ok;
  logic       w_ok_acc;

  assign w_first = (r_cnt == '0);
  // The first sample word becomes the reference and is compared against itself.
  assign w_ref   = w_first ? i_data : r_ref;

`ifdef BCLK_TRAIN_EYE_MON_EN
  assign w_eye_ok = !i_eye_early && !i_eye_late;
`else
  logic w_unused_eye;
  assign w_unused_eye = i_eye_early ^ i_eye_late;
  assign w_eye_ok     = 1'b1;
`endif

  assign w_word_ok = (i_data == w_ref) && !word_rejected(w_ref) && w_eye_ok;
  assign w_ok_acc  = (w_first || r_ok) && w_word_ok;

  assign o_settle_done = (r_phase == CHK_SETTLE) && (r_cnt == SETTLE_LAST);
  assign o_done        = (r_phase == CHK_SAMPLE) && (r_cnt == SAMPLE_LAST);
  assign o_pass        = r_pass;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= CHK_IDLE;
      r_cnt   <= '0;
      r_ref   <= '0;
      r_ok    <= 1'b0;
      r_pass  <= 1'b0;
    end else if (i_start) begin
      r_phase <= CHK_SETTLE;
      r_cnt   <= '0;
    end else begin
      case (r_phase)
        CHK_SETTLE: begin
          if (o_settle_done) begin
            r_phase <= CHK_SAMPLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        CHK_SAMPLE: begin
          r_ref <= w_ref;
          r_ok  <= w_ok_acc;
          if (o_done) begin
            r_pass  <= w_ok_acc;
            r_phase <= CHK_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bclk_train_ctrl.sv
// BCLK training: sweeps the lane delay line, finds the longest passing window and
// parks the line at its centre. CLEAR/eye gating enabled by BCLK_TRAIN_EYE_MON_EN.
module bclk_train_ctrl
  import bclk_train_pkg::*;
#(
  parameter int unsigned TAP_W         = DEF_TAP_W,
  parameter int unsigned MAX_TAPS      = DEF_MAX_TAPS,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic             FAB_CLK,
  input  logic             ARST,
  input  logic             START,
  input  logic [7:0]       RX_DATA,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] CENTER_TAP
);

  localparam int unsigned      LW       = TAP_W + 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(MAX_TAPS - 1);
`ifdef BCLK_TRAIN_EYE_MON_EN
  localparam train_state_t S_POST_MOVE = S_CLEAR;
`else
  localparam train_state_t S_POST_MOVE = S_SETTLE;
`endif

  train_state_t     r_state;
  train_state_t     w_next;
  logic [TAP_W-1:0] r_tap;
  logic [TAP_W-1:0] r_center;
  logic             r_run_open;
  logic [TAP_W-1:0] r_run_start;
  logic [LW-1:0]    r_run_len;
  logic [TAP_W-1:0] r_best_start;
  logic [LW-1:0]    r_best_len;
  logic             r_seek_wait;
  logic             r_move;
  logic             r_load;

  logic             w_chk_start;
  logic             w_chk_settle_done;
  logic             w_chk_done;
  logic             w_chk_pass;
  logic             w_last;
  logic             w_seek_req;
  logic             w_close;
  logic [LW-1:0]    w_run_len_n;
  logic [TAP_W-1:0] w_run_start_n;
  logic [TAP_W-1:0] w_center;

  bclk_sample_chk #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SAMPLE_CYCLES (SAMPLE_CYCLES)
  ) u_chk (
    .i_clk         (FAB_CLK),
    .i_rst         (ARST),
    .i_start       (w_chk_start),
    .i_data        (RX_DATA),
    .i_eye_early   (EYE_MONITOR_EARLY),
    .i_eye_late    (EYE_MONITOR_LATE),
    .o_settle_done (w_chk_settle_done),
    .o_done        (w_chk_done),
    .o_pass        (w_chk_pass)
  );

  assign w_chk_start = (w_next == S_SETTLE) && (r_state != S_SETTLE);
  assign w_last      = (r_tap == LAST_TAP) || DELAY_LINE_OUT_OF_RANGE;

  // A passing tap on the final sweep position closes its run including itself.
  assign w_run_len_n   = w_chk_pass ? (r_run_open ? r_run_len + LW'(1) : LW'(1)) : r_run_len;
  assign w_run_start_n = (w_chk_pass && !r_run_open) ? r_tap : r_run_start;
  assign w_close       = (r_run_open && !w_chk_pass) || (w_chk_pass && w_last);
  assign w_center      = r_best_start + TAP_W'((r_best_len - LW'(1)) >> 1);

  always_comb begin
    w_next     = r_state;
    w_seek_req = 1'b0;
    case (r_state)
      S_IDLE:   if (START) w_next = S_LOAD;
      S_LOAD:   w_next = S_POST_MOVE;
      S_CLEAR:  w_next = S_SETTLE;
      S_SETTLE: if (w_chk_settle_done) w_next = S_SAMPLE;
      S_SAMPLE: if (w_chk_done) w_next = S_EVAL;
      S_EVAL:   w_next = w_last ? S_CALC : S_STEP;
      S_STEP:   w_next = S_POST_MOVE;
      S_CALC:   w_next = (r_best_len == '0) ? S_FAIL : S_RELOAD;
      S_RELOAD: w_next = S_SEEK;
      // Seek requests a move on alternate cycles; the registered pulse lands one cycle later.
      S_SEEK: begin
        if (r_tap == r_center) w_next = S_DONE;
        else if (!r_seek_wait) w_seek_req = 1'b1;
      end
      S_DONE:   if (START) w_next = S_LOAD;
      S_FAIL:   if (START) w_next = S_LOAD;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_state      <= S_IDLE;
      r_tap        <= '0;
      r_center     <= '0;
      r_run_open   <= 1'b0;
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
      r_seek_wait  <= 1'b0;
      r_move       <= 1'b0;
      r_load       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_load  <= (w_next == S_LOAD) || (w_next == S_RELOAD);
      r_move  <= (w_next == S_STEP) || w_seek_req;
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (START) begin
            r_center     <= '0;
            r_run_open   <= 1'b0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
          end
        end
        S_LOAD: r_tap <= '0;
        S_EVAL: begin
          if (w_close && (w_run_len_n > r_best_len)) begin
            r_best_start <= w_run_start_n;
            r_best_len   <= w_run_len_n;
          end
          r_run_open  <= w_chk_pass && !w_last;
          r_run_len   <= w_chk_pass ? w_run_len_n : '0;
          r_run_start <= w_run_start_n;
        end
        S_STEP: r_tap <= r_tap + TAP_W'(1);
        S_CALC: if (r_best_len != '0) r_center <= w_center;
        S_RELOAD: begin
          r_tap       <= '0;
          r_seek_wait <= 1'b0;
        end
        S_SEEK: begin
          if (w_seek_req) r_tap <= r_tap + TAP_W'(1);
          r_seek_wait <= w_seek_req;
        end
        default: ;
      endcase
    end
  end

`ifdef BCLK_TRAIN_EYE_MON_EN
  logic r_clr;
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) r_clr <= 1'b0;
    else      r_clr <= (w_next == S_CLEAR);
  end
  assign EYE_MONITOR_CLEAR_FLAGS = r_clr;
`else
  assign EYE_MONITOR_CLEAR_FLAGS = 1'b0;
`endif

  assign DELAY_LINE_MOVE      = r_move;
  assign DELAY_LINE_DIRECTION = r_move;
  assign DELAY_LINE_LOAD      = r_load;
  assign BUSY                 = !(r_state inside {S_IDLE, S_DONE, S_FAIL});
  assign DONE                 = (r_state == S_DONE);
  assign FAIL                 = (r_state == S_FAIL);
  assign CENTER_TAP           = r_center;

endmodule

// File: tb/tb_bclk_train_ctrl.sv
// Directed bench for bclk_train_ctrl with a behavioural lane/delay-line model.
module tb_bclk_train_ctrl;

`ifdef BCLK_TRAIN_EYE_MON_EN
  localparam int EYE_EXP = 60;
`else
  localparam int EYE_EXP = 55;
`endif

  logic       FAB_CLK = 1'b0;
  logic       ARST    = 1'b1;
  logic       START   = 1'b0;
  logic [7:0] RX_DATA;
  logic       EYE_MONITOR_EARLY;
  logic       EYE_MONITOR_LATE;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_LOAD;
  logic       EYE_MONITOR_CLEAR_FLAGS;
  logic       BUSY;
  logic       DONE;
  logic       FAIL;
  logic [7:0] CENTER_TAP;

  int checks   = 0;
  int failures = 0;

  // lane model configuration (a window with lo > hi is disabled)
  int         w1_lo = 999, w1_hi = -1, w2_lo = 999, w2_hi = -1;
  int         oor_tap = 999, eye_lo = 999, eye_hi = -1;
  bit         fill_en = 1'b0;
  logic [7:0] fill_val = 8'h00;

  bclk_train_ctrl #(
    .TAP_W         (8),
    .MAX_TAPS      (128),
    .SETTLE_CYCLES (8),
    .SAMPLE_CYCLES (16)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST                    (ARST),
    .START                   (START),
    .RX_DATA                 (RX_DATA),
    .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .BUSY                    (BUSY),
    .DONE                    (DONE),
    .FAIL                    (FAIL),
    .CENTER_TAP              (CENTER_TAP)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int         lane_tap = 0;
  logic [7:0] noise = 8'h00;

  always @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) lane_tap <= 0;
    else if (DELAY_LINE_LOAD) lane_tap <= 0;
    else if (DELAY_LINE_MOVE && DELAY_LINE_DIRECTION) lane_tap <= lane_tap + 1;
  end

  always @(posedge FAB_CLK) noise <= noise + 8'd1;

  always_comb begin
    RX_DATA = noise;
    if (fill_en) RX_DATA = fill_val;
    else if ((lane_tap >= w1_lo && lane_tap <= w1_hi) || (lane_tap >= w2_lo && lane_tap <= w2_hi))
      RX_DATA = 8'h5A;
    EYE_MONITOR_EARLY       = 1'b0;
    EYE_MONITOR_LATE        = (lane_tap >= eye_lo) && (lane_tap <= eye_hi);
    DELAY_LINE_OUT_OF_RANGE = (lane_tap >= oor_tap);
  end

  // pulse bookkeeping: loads/moves since START, clears, pulse-rule violations
  int   n_loads = 0, n_moves = 0, n_clrs = 0;
  bit   viol = 1'b0;
  logic p_move = 1'b0, p_load = 1'b0, p_clr = 1'b0;

  always @(posedge FAB_CLK) begin
    if (START && !BUSY) begin
      n_loads <= 0;
      n_moves <= 0;
    end else if (DELAY_LINE_LOAD) begin
      n_loads <= n_loads + 1;
      n_moves <= 0;
    end else if (DELAY_LINE_MOVE) begin
      n_moves <= n_moves + 1;
    end
    if (EYE_MONITOR_CLEAR_FLAGS) n_clrs <= n_clrs + 1;
    if ((int'(DELAY_LINE_MOVE) + int'(DELAY_LINE_LOAD) + int'(EYE_MONITOR_CLEAR_FLAGS)) > 1 ||
        (DELAY_LINE_MOVE && p_move) || (DELAY_LINE_LOAD && p_load) || (EYE_MONITOR_CLEAR_FLAGS && p_clr))
      viol <= 1'b1;
    p_move <= DELAY_LINE_MOVE;
    p_load <= DELAY_LINE_LOAD;
    p_clr  <= EYE_MONITOR_CLEAR_FLAGS;
  end

  task automatic set_lane(input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                          input int oor, input int e_lo, input int e_hi);
    fill_en = 1'b0;
    w1_lo = a_lo; w1_hi = a_hi; w2_lo = b_lo; w2_hi = b_hi;
    oor_tap = oor; eye_lo = e_lo; eye_hi = e_hi;
  endtask

  task automatic run_training(output bit timed_out);
    @(negedge FAB_CLK) START = 1'b1;
    @(negedge FAB_CLK) START = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      if (DONE || FAIL) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge FAB_CLK);
    end
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    repeat (2) @(negedge FAB_CLK);
    outs = {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, FAIL};
    checks++;
    if (outs !== 7'b0 || CENTER_TAP !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: got outs=%b center=%0d, need 0 0", outs, CENTER_TAP);
    end
    ARST = 1'b0;
    repeat (6) @(negedge FAB_CLK);
    outs = {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, FAIL};
    checks++;
    if (outs !== 7'b0 || n_loads !== 0) begin
      failures++;
      $display("FAIL idle_after_reset: got outs=%b loads=%0d, need 0 0", outs, n_loads);
    end
  endtask

  typedef struct {
    string name;
    int    a_lo, a_hi, b_lo, b_hi, oor, e_lo, e_hi, exp_center;
  } vec_t;

  task automatic test_window_sweep();
    vec_t v[6];
    bit   to;
    v[0] = '{"one_window",   40,  71, 999, -1, 999, 999, -1, 55};
    v[1] = '{"two_windows",  10,  19,  80, 89, 999, 999, -1, 14};
    v[2] = '{"out_of_range", 50,  60, 999, -1,  60, 999, -1, 55};
    v[3] = '{"eye_late",     40,  71, 999, -1, 999,  45, 49, EYE_EXP};
    v[4] = '{"center_zero",   0,   1, 999, -1, 999, 999, -1, 0};
    v[5] = '{"end_window",  120, 127, 999, -1, 999, 999, -1, 123};
    for (int k = 0; k < 6; k++) begin
      set_lane(v[k].a_lo, v[k].a_hi, v[k].b_lo, v[k].b_hi, v[k].oor, v[k].e_lo, v[k].e_hi);
      run_training(to);
      @(negedge FAB_CLK);
      checks++;
      if (to) begin
        failures++;
        $display("FAIL %s_timeout: got no DONE/FAIL in budget, need completion", v[k].name);
      end
      checks++;
      if ({DONE, FAIL, BUSY} !== 3'b100) begin
        failures++;
        $display("FAIL %s_status: got done/fail/busy=%b, need 100", v[k].name, {DONE, FAIL, BUSY});
      end
      checks++;
      if (int'(CENTER_TAP) !== v[k].exp_center) begin
        failures++;
        $display("FAIL %s_center: got %0d, need %0d", v[k].name, CENTER_TAP, v[k].exp_center);
      end
      checks++;
      if (n_loads !== 2) begin
        failures++;
        $display("FAIL %s_loads: got %0d, need 2", v[k].name, n_loads);
      end
      checks++;
      if (n_moves !== v[k].exp_center) begin
        failures++;
        $display("FAIL %s_seek_moves: got %0d, need %0d", v[k].name, n_moves, v[k].exp_center);
      end
      checks++;
      if (lane_tap !== v[k].exp_center) begin
        failures++;
        $display("FAIL %s_lane_tap: got %0d, need %0d", v[k].name, lane_tap, v[k].exp_center);
      end
    end
  endtask

  task automatic test_reject();
    logic [7:0] pat [2];
    bit         to;
    pat[0] = 8'hFF;
    pat[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      set_lane(999, -1, 999, -1, 999, 999, -1);
      fill_en  = 1'b1;
      fill_val = pat[k];
      run_training(to);
      @(negedge FAB_CLK);
      checks++;
      if (to || {DONE, FAIL, BUSY} !== 3'b010) begin
        failures++;
        $display("FAIL reject_%h_status: got timeout=%0d done/fail/busy=%b, need 0 010", pat[k], to, {DONE, FAIL, BUSY});
      end
      checks++;
      if (CENTER_TAP !== 8'd0) begin
        failures++;
        $display("FAIL reject_%h_center: got %0d, need 0", pat[k], CENTER_TAP);
      end
      checks++;
      if (n_loads !== 1 || n_moves !== 127) begin
        failures++;
        $display("FAIL reject_%h_pulses: got loads=%0d moves=%0d, need 1 127", pat[k], n_loads, n_moves);
      end
    end
    fill_en = 1'b0;
  endtask

  task automatic test_restart();
    bit to;
    set_lane(40, 71, 999, -1, 999, 999, -1);
    run_training(to);
    checks++;
    if (to || !DONE || CENTER_TAP !== 8'd55) begin
      failures++;
      $display("FAIL restart_first: got timeout=%0d done=%0d center=%0d, need 0 1 55", to, DONE, CENTER_TAP);
    end
    @(negedge FAB_CLK) START = 1'b1;
    @(negedge FAB_CLK) START = 1'b0;
    checks++;
    if ({DONE, FAIL, BUSY, DELAY_LINE_LOAD} !== 4'b0011 || CENTER_TAP !== 8'd0) begin
      failures++;
      $display("FAIL restart_entry: got done/fail/busy/load=%b center=%0d, need 0011 0",
               {DONE, FAIL, BUSY, DELAY_LINE_LOAD}, CENTER_TAP);
    end
    repeat (200) @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK) START = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      if (DONE || FAIL) begin
        to = 1'b0;
        break;
      end
      @(negedge FAB_CLK);
    end
    checks++;
    if (to || !DONE || CENTER_TAP !== 8'd55) begin
      failures++;
      $display("FAIL restart_second: got timeout=%0d done=%0d center=%0d, need 0 1 55", to, DONE, CENTER_TAP);
    end
    checks++;
    if (n_loads !== 2 || n_moves !== 55) begin
      failures++;
      $display("FAIL restart_busy_start: got loads=%0d moves=%0d, need 2 55", n_loads, n_moves);
    end
  endtask

  task automatic test_reset_mid_seek();
    bit         to;
    logic [6:0] outs;
    set_lane(40, 71, 999, -1, 999, 999, -1);
    @(negedge FAB_CLK) START = 1'b1;
    @(negedge FAB_CLK) START = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      if (n_loads == 2 && n_moves == 20) begin
        to = 1'b0;
        break;
      end
      @(negedge FAB_CLK);
    end
    checks++;
    if (to) begin
      failures++;
      $display("FAIL midseek_reach: got no seek progress in budget, need 20 seek moves");
    end
    #2 ARST = 1'b1;
    #1;
    outs = {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS, BUSY, DONE, FAIL};
    checks++;
    if (outs !== 7'b0 || CENTER_TAP !== 8'd0) begin
      failures++;
      $display("FAIL midseek_async_clear: got outs=%b center=%0d, need 0 0", outs, CENTER_TAP);
    end
    @(negedge FAB_CLK) ARST = 1'b0;
    repeat (10) @(negedge FAB_CLK);
    checks++;
    if (BUSY !== 1'b0 || DELAY_LINE_LOAD !== 1'b0) begin
      failures++;
      $display("FAIL midseek_stays_idle: got busy=%0d load=%0d, need 0 0", BUSY, DELAY_LINE_LOAD);
    end
    run_training(to);
    checks++;
    if (to || !DONE || CENTER_TAP !== 8'd55) begin
      failures++;
      $display("FAIL midseek_retrain: got timeout=%0d done=%0d center=%0d, need 0 1 55", to, DONE, CENTER_TAP);
    end
    checks++;
    if (n_loads !== 2 || n_moves !== 55 || lane_tap !== 55) begin
      failures++;
      $display("FAIL midseek_retrain_pulses: got loads=%0d moves=%0d tap=%0d, need 2 55 55", n_loads, n_moves, lane_tap);
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (viol !== 1'b0) begin
      failures++;
      $display("FAIL pulse_rules: got violation=%0d, need 0", viol);
    end
    checks++;
`ifdef BCLK_TRAIN_EYE_MON_EN
    if (n_clrs == 0) begin
      failures++;
      $display("FAIL clear_pulses: got %0d, need nonzero", n_clrs);
    end
`else
    if (n_clrs != 0) begin
      failures++;
      $display("FAIL clear_pulses: got %0d, need 0", n_clrs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_window_sweep();
    test_reject();
    test_restart();
    test_reset_mid_seek();
    test_pulse_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bclk_train_ctrl.md
BCLK_TRAIN_CTRL -- requirements
Module: bclk_train_ctrl

Interface
REQ-001 SHALL have parameter TAP_W, 8, delay-line tap index width.
REQ-002 SHALL have parameter MAX_TAPS, 128, number of taps swept; legal range 2..2**TAP_W.
REQ-003 SHALL have parameter SETTLE_CYCLES, 8, idle cycles after each tap change before sampling; minimum 1.
REQ-004 SHALL have parameter SAMPLE_CYCLES, 16, RX_DATA words checked per tap; minimum 1.
REQ-005 SHALL have port FAB_CLK, input, 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port ARST, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port START, input, 1: one-cycle request to begin training.
REQ-008 SHALL have port RX_DATA, input, 8: deserialized BCLK word from the lane.
REQ-009 SHALL have ports EYE_MONITOR_EARLY and EYE_MONITOR_LATE, input, 1 each: sticky eye-monitor flags.
REQ-010 SHALL have port DELAY_LINE_OUT_OF_RANGE, input, 1: delay line at its limit.
REQ-011 SHALL have ports DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS, output, 1 each: lane delay-line and eye-monitor controls.
REQ-012 SHALL have ports BUSY, DONE, FAIL, output, 1 each, and CENTER_TAP, output, TAP_W: training status and result.

Function
REQ-013 SHALL use states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, CALC, RELOAD, SEEK, DONE, FAIL.
REQ-014 IDLE: START=1 -> LOAD; DONE/FAIL cleared the same cycle; START ignored in all other states except DONE and FAIL, where it restarts training identically.
REQ-015 LOAD: DELAY_LINE_LOAD high exactly one cycle, internal tap counter := 0 -> CLEAR.
REQ-016 CLEAR: EYE_MONITOR_CLEAR_FLAGS high exactly one cycle -> SETTLE.
REQ-017 SETTLE: count SETTLE_CYCLES cycles -> SAMPLE.
REQ-018 SAMPLE: capture first word as reference; tap passes only if all SAMPLE_CYCLES words equal the reference, the reference is neither 8'h00 nor 8'hFF, and the eye criterion (REQ-030) holds; -> EVAL.
REQ-019 EVAL: update run tracking: a pass extends the current run (start recorded at first pass tap); a fail closes it; a closed run strictly longer than the best replaces best (ties keep the earlier run).
REQ-020 EVAL -> CALC if tap = MAX_TAPS-1 or DELAY_LINE_OUT_OF_RANGE=1, else -> STEP; an open run is closed at sweep end.
REQ-021 STEP: DELAY_LINE_MOVE high one cycle with DELAY_LINE_DIRECTION=1, tap+1 -> CLEAR.
REQ-022 CALC: best length 0 -> FAIL; else CENTER_TAP := best_start + (best_len-1)/2 (floor) -> RELOAD.
REQ-023 RELOAD: DELAY_LINE_LOAD one cycle, tap := 0 -> SEEK.
REQ-024 SEEK: while tap < CENTER_TAP, one MOVE pulse (DIRECTION=1) every 2 cycles, tap+1 per pulse; tap = CENTER_TAP -> DONE; CENTER_TAP=0 -> DONE with no MOVE.
REQ-025 DONE/FAIL: DONE or FAIL held high, CENTER_TAP held, until START or reset.
REQ-026 BUSY SHALL be high in every state except IDLE, DONE, FAIL.
REQ-027 DELAY_LINE_MOVE, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS SHALL be registered, mutually exclusive, never high two consecutive cycles.

Reset
REQ-028 ARST=1 SHALL immediately force state IDLE, all outputs 0 (CENTER_TAP=0), counters and run tracking 0, including mid-sweep or mid-seek.
REQ-029 After ARST deassertion, block SHALL remain IDLE until START.

Configuration
REQ-030 With BCLK_TRAIN_EYE_MON_EN defined, a tap SHALL pass only if EYE_MONITOR_EARLY=0 and EYE_MONITOR_LATE=0 on every SAMPLE cycle; CLEAR state is used.
REQ-031 Without BCLK_TRAIN_EYE_MON_EN, eye inputs SHALL be ignored, EYE_MONITOR_CLEAR_FLAGS tied 0, CLEAR skipped (LOAD/STEP -> SETTLE directly).

Structure
REQ-032 Package bclk_train_pkg SHALL hold the state enum, default parameter constants, and PASS_REJECT patterns 8'h00/8'hFF.
REQ-033 Sub-module bclk_sample_chk SHALL implement SETTLE/SAMPLE counting and pass/fail decision with start/done handshake.

Verification
REQ-034 Lane model passes taps 40..71, MAX_TAPS=128 -> CENTER_TAP=55, DONE=1, 55 MOVE pulses after second LOAD.
REQ-035 Two windows 10..19 and 80..89 -> tie keeps first, CENTER_TAP=14.
REQ-036 RX_DATA constant 8'hFF all taps -> FAIL=1, DONE=0, no SEEK MOVE pulses.
REQ-037 OUT_OF_RANGE asserted at tap 60 with pass 50..60 -> sweep ends, CENTER_TAP=55.
REQ-038 EYE_MONITOR_LATE=1 on taps 45..49 within pass 40..71 (macro defined) -> best 50..71, CENTER_TAP=60; macro undefined -> CENTER_TAP=55.
REQ-039 ARST pulse during SEEK -> all outputs 0 same cycle; subsequent START repeats full training with identical result.
